// File: rtl/usr_sequencer.sv
// Command sequencer for an external universal shift register (USR):
// optional parallel load, N shift cycles, then capture of the USR output.
// Ports:
//   clk, rst                       clock and synchronous active-high reset
//   cmd_valid/ready                command handshake
//   cmd_load/dir/count/data        command fields (latched on acceptance)
//   usr_select, usr_d_in, usr_q    USR control, load data and feedback
//   busy, done, result             status, completion pulse, captured value
module usr_sequencer #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_load,
  input  logic             cmd_dir,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic [WIDTH-1:0] cmd_data,
  output logic [1:0]       usr_select,
  output logic [WIDTH-1:0] usr_d_in,
  input  logic [WIDTH-1:0] usr_q,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    CAPTURE
  } state_t;

  localparam logic [1:0] SEL_HOLD = 2'b00;
  localparam logic [1:0] SEL_SHR  = 2'b01;
  localparam logic [1:0] SEL_SHL  = 2'b10;
  localparam logic [1:0] SEL_LOAD = 2'b11;

  state_t           state_q, state_d;
  logic [1:0]       sel_q, sel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             load_q, load_d;
  logic             dir_q, dir_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] result_q, result_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    load_d   = load_q;
    dir_d    = dir_q;
    data_d   = data_q;
    result_d = result_q;
    done_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          load_d = cmd_load;
          dir_d  = cmd_dir;
          cnt_d  = cmd_count;
          data_d = cmd_data;
          if (cmd_load) begin
            state_d = LOAD;
          end else if (cmd_count != '0) begin
            state_d = SHIFT;
          end else begin
            state_d = CAPTURE;
          end
        end
      end
      LOAD: begin
        if (cnt_q != '0) begin
          state_d = SHIFT;
        end else begin
          state_d = CAPTURE;
        end
      end
      SHIFT: begin
        // Counter holds the shifts still owed including this cycle.
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q <= CNT_W'(1)) begin
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        result_d = usr_q;
        done_d   = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Select is registered alongside the state it belongs to, so it
    // never sees cmd_* combinationally.
    unique case (state_d)
      LOAD:    sel_d = SEL_LOAD;
      SHIFT:   sel_d = dir_d ? SEL_SHL : SEL_SHR;
      default: sel_d = SEL_HOLD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      sel_q    <= SEL_HOLD;
      cnt_q    <= '0;
      load_q   <= 1'b0;
      dir_q    <= 1'b0;
      data_q   <= '0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      cnt_q    <= cnt_d;
      load_q   <= load_d;
      dir_q    <= dir_d;
      data_q   <= data_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign cmd_ready  = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign usr_select = sel_q;
  assign usr_d_in   = data_q;
  assign done       = done_q;
  assign result     = result_q;

  logic unused_load;
  assign unused_load = load_q;

endmodule
